seq_bin_to_bcd: RTL and testbench



---
 rtl/seq_bin_to_bcd_pkg.sv | 16 +
 rtl/seq_bin_to_bcd_if.sv | 24 ++
 rtl/seq_bin_to_bcd_add3_digit.sv | 12 +
 rtl/seq_bin_to_bcd.sv | 118 +++++++++++
 tb/tb_seq_bin_to_bcd.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/seq_bin_to_bcd_pkg.sv
// Shared definitions for the iterative double-dabble binary-to-BCD converter.
package seq_bin_to_bcd_pkg;

    localparam int unsigned DEF_WIDTH  = 16;
    localparam int unsigned DEF_DIGITS = 5;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Counter width able to hold the value w (the number of shifts).
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/seq_bin_to_bcd_if.sv
// Start/busy/done handshake and result bus of the binary-to-BCD converter.
interface seq_bin_to_bcd_if
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
);
    logic                  i_start;
    logic [WIDTH-1:0]      i_bin;
    logic                  o_busy;
    logic                  o_done;
    logic [4*DIGITS-1:0]   o_bcd;
    logic [DIGITS-1:0]     o_blank;

    modport master (
        output i_start, i_bin,
        input  o_busy, o_done, o_bcd, o_blank
    );

    modport slave (
        input  i_start, i_bin,
        output o_busy, o_done, o_bcd, o_blank
    );
endinterface

// File: rtl/seq_bin_to_bcd_add3_digit.sv
// One BCD digit correction: add 3 when the digit is 5 or more, before the shift doubles it.
module bcd_add3_digit (
    input  logic [3:0] digit_i,
    output logic [3:0] digit_c_o
);
    always_comb begin
        digit_c_o = digit_i;
        if (digit_i >= 4'd5) begin
            digit_c_o = digit_i + 4'd3;
        end
    end
endmodule

// File: rtl/seq_bin_to_bcd.sv
// Iterative shift-add-3 binary-to-BCD converter, one bit per clock, with
// leading-zero flags for display blanking.
module seq_bin_to_bcd
    import seq_bin_to_bcd_pkg::*;
#(
    parameter int unsigned WIDTH  = DEF_WIDTH,
    parameter int unsigned DIGITS = DEF_DIGITS
) (
    input  logic              i_clk,
    input  logic              i_rst,
    seq_bin_to_bcd_if.slave   bus
);
    localparam int unsigned CNT_W = cnt_width(WIDTH);
    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_RST = ~DIGITS'(1);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  bin_q, bin_d, bin_shift;
    logic [BCD_W-1:0]  scr_q, scr_d, scr_adj, scr_shift;
    logic [BCD_W-1:0]  bcd_q, bcd_d;
    logic [DIGITS-1:0] blank_q, blank_d, blank_shift;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              all_zero;

    for (genvar g = 0; g < int'(DIGITS); g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_i   (scr_q[4*g +: 4]),
            .digit_c_o (scr_adj[4*g +: 4])
        );
    end

    // Corrected scratch and binary shift left as one register; bin MSB enters digit 0.
    assign {scr_shift, bin_shift} = {scr_adj, bin_q} << 1;

    // A digit is blank when it and every digit above it are zero; digit 0 never blanks.
    always_comb begin
        all_zero    = 1'b1;
        blank_shift = '0;
        for (int k = int'(DIGITS) - 1; k >= 1; k--) begin
            all_zero       = all_zero & (scr_shift[4*k +: 4] == 4'd0);
            blank_shift[k] = all_zero;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        scr_d   = scr_q;
        bcd_d   = bcd_q;
        blank_d = blank_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                busy_d = 1'b0;
                if (bus.i_start) begin
                    bin_d   = bus.i_bin;
                    scr_d   = '0;
                    cnt_d   = CNT_W'(WIDTH);
                    busy_d  = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                scr_d = scr_shift;
                bin_d = bin_shift;
                cnt_d = cnt_q - CNT_W'(1);
                // Last shift: publish the result so it is valid alongside done.
                if (cnt_q == CNT_W'(1)) begin
                    bcd_d   = scr_shift;
                    blank_d = blank_shift;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            scr_q   <= '0;
            bcd_q   <= '0;
            blank_q <= BLANK_RST;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            scr_q   <= scr_d;
            bcd_q   <= bcd_d;
            blank_q <= blank_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign bus.o_busy  = busy_q;
    assign bus.o_done  = done_q;
    assign bus.o_bcd   = bcd_q;
    assign bus.o_blank = blank_q;

endmodule

// File: tb/tb_seq_bin_to_bcd.sv
// Randomised self-checking bench for seq_bin_to_bcd: a 16-bit/5-digit and an 8-bit/3-digit instance.
module tb_seq_bin_to_bcd;
    localparam int WA = 16;
    localparam int DA = 5;
    localparam int WB = 8;
    localparam int DB = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    seq_bin_to_bcd_if #(.WIDTH(WA), .DIGITS(DA)) ifa ();
    seq_bin_to_bcd_if #(.WIDTH(WB), .DIGITS(DB)) ifb ();

    seq_bin_to_bcd #(.WIDTH(WA), .DIGITS(DA)) dut_a (.i_clk(clk), .i_rst(rst), .bus(ifa));
    seq_bin_to_bcd #(.WIDTH(WB), .DIGITS(DB)) dut_b (.i_clk(clk), .i_rst(rst), .bus(ifb));

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Decimal digits of v, ones digit in the low nibble.
    function automatic logic [19:0] to_bcd(input int v);
        int t = v;
        logic [19:0] r = '0;
        for (int k = 0; k < 5; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    // Digit k (k>0) is a leading zero exactly when v < 10^k.
    function automatic logic [4:0] blank_of(input int v, input int d);
        logic [4:0] r = '0;
        int p = 10;
        for (int k = 1; k < d; k++) begin
            r[k] = (v < p);
            p = p * 10;
        end
        return r;
    endfunction

    // Model phase: 0 idle, 1..W busy, W+1 done pulse. r* is the last completed value.
    int pa = 0, capa = 0, ra = 0;
    int pb = 0, capb = 0, rb = 0;

    always @(posedge clk) begin
        if (rst) begin
            pa = 0; ra = 0;
            pb = 0; rb = 0;
        end else begin
            if (pa == 0) begin
                if (ifa.i_start === 1'b1) begin capa = int'(ifa.i_bin); pa = 1; end
            end else if (pa == WA) begin
                ra = capa; pa = WA + 1;
            end else if (pa == WA + 1) begin
                pa = 0;
            end else begin
                pa++;
            end
            if (pb == 0) begin
                if (ifb.i_start === 1'b1) begin capb = int'(ifb.i_bin); pb = 1; end
            end else if (pb == WB) begin
                rb = capb; pb = WB + 1;
            end else if (pb == WB + 1) begin
                pb = 0;
            end else begin
                pb++;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("a_busy",  32'(ifa.o_busy),  32'(pa >= 1 && pa <= WA));
            chk("a_done",  32'(ifa.o_done),  32'(pa == WA + 1));
            chk("a_bcd",   32'(ifa.o_bcd),   32'(to_bcd(ra)));
            chk("a_blank", 32'(ifa.o_blank), 32'(blank_of(ra, DA)));
            chk("b_busy",  32'(ifb.o_busy),  32'(pb >= 1 && pb <= WB));
            chk("b_done",  32'(ifb.o_done),  32'(pb == WB + 1));
            chk("b_bcd",   32'(ifb.o_bcd),   32'(to_bcd(rb)));
            chk("b_blank", 32'(ifb.o_blank), 32'(blank_of(rb, DB)));
        end
    end

    // One conversion on instance a (sel=0) or b (sel=1); n = edges from accept to done inclusive.
    task automatic run(input bit sel, input int v, output int n, output int bc,
                       output logic [19:0] bcd, output logic [4:0] bl);
        logic dn;
        @(negedge clk);
        if (sel) begin ifb.i_bin = 8'(v);  ifb.i_start = 1'b1; end
        else     begin ifa.i_bin = 16'(v); ifa.i_start = 1'b1; end
        n = 0; bc = 0; dn = 1'b0;
        do begin
            @(posedge clk); #1;
            n++;
            if (n == 1) begin ifa.i_start = 1'b0; ifb.i_start = 1'b0; end
            if ((sel ? ifb.o_busy : ifa.o_busy) === 1'b1) bc++;
            dn = sel ? ifb.o_done : ifa.o_done;
        end while (dn !== 1'b1 && n < 60);
        bcd = sel ? 20'(ifb.o_bcd) : ifa.o_bcd;
        bl  = sel ? 5'(ifb.o_blank) : ifa.o_blank;
        @(posedge clk); #1;
    endtask

    initial begin
        int n, bc, m;
        logic [19:0] bcd;
        logic [4:0]  bl;

        ifa.i_start = 1'b0; ifa.i_bin = '0;
        ifb.i_start = 1'b0; ifb.i_bin = '0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        chk("rst_a_busy",  32'(ifa.o_busy),  32'h0);
        chk("rst_a_done",  32'(ifa.o_done),  32'h0);
        chk("rst_a_bcd",   32'(ifa.o_bcd),   32'h0);
        chk("rst_a_blank", 32'(ifa.o_blank), 32'b11110);
        chk("rst_b_blank", 32'(ifb.o_blank), 32'b110);
        rst = 1'b0;

        run(0, 20000, n, bc, bcd, bl);
        chk("lat_20000",   32'(n),   32'd17);
        chk("bcd_20000",   32'(bcd), 32'h20000);
        chk("blank_20000", 32'(bl),  32'b00000);

        run(0, 65535, n, bc, bcd, bl);
        chk("busy_65535", 32'(bc),  32'd16);
        chk("bcd_65535",  32'(bcd), 32'h65535);

        run(0, 0, n, bc, bcd, bl);
        chk("bcd_0",   32'(bcd), 32'h00000);
        chk("blank_0", 32'(bl),  32'b11110);

        // Start held high; bin changes mid-conversion.
        @(negedge clk);
        ifa.i_bin = 16'd42; ifa.i_start = 1'b1;
        n = 0;
        do begin
            @(posedge clk); #1; n++;
            if (n == 3) ifa.i_bin = 16'd999;
        end while (ifa.o_done !== 1'b1 && n < 60);
        chk("lat_42",   32'(n),             32'd17);
        chk("bcd_42",   32'(ifa.o_bcd),     32'h00042);
        chk("blank_42", 32'(ifa.o_blank),   32'b11100);
        m = 0;
        do begin
            @(posedge clk); #1; m++;
        end while (ifa.o_done !== 1'b1 && m < 60);
        chk("period_held", 32'(m),           32'd18);
        chk("bcd_999",     32'(ifa.o_bcd),   32'h00999);
        chk("blank_999",   32'(ifa.o_blank), 32'b11000);
        @(negedge clk);
        ifa.i_start = 1'b0;
        repeat (2) @(posedge clk);

        // Reset in the middle of a conversion.
        @(negedge clk);
        ifa.i_bin = 16'd1234; ifa.i_start = 1'b1;
        @(posedge clk); #1;
        ifa.i_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy",  32'(ifa.o_busy),  32'h0);
        chk("abort_done",  32'(ifa.o_done),  32'h0);
        chk("abort_bcd",   32'(ifa.o_bcd),   32'h0);
        chk("abort_blank", 32'(ifa.o_blank), 32'b11110);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(posedge clk);
        run(0, 1234, n, bc, bcd, bl);
        chk("bcd_1234",   32'(bcd), 32'h01234);
        chk("blank_1234", 32'(bl),  32'b10000);

        run(1, 255, n, bc, bcd, bl);
        chk("b_lat_255",   32'(n),   32'd9);
        chk("b_bcd_255",   32'(bcd), 32'h255);
        chk("b_blank_255", 32'(bl),  32'b000);

        for (int v = 0; v < 256; v++) begin
            run(1, v, n, bc, bcd, bl);
            chk("b_sweep_lat", 32'(n), 32'd9);
        end

        for (int i = 0; i < 30; i++) begin
            run(0, int'($urandom_range(0, 65535)), n, bc, bcd, bl);
            chk("a_rand_lat", 32'(n), 32'd17);
        end

        // Free-running random starts, bins and occasional resets; the model tracks acceptance.
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            ifa.i_start = 1'($urandom_range(0, 3) == 0);
            ifa.i_bin   = 16'($urandom);
            ifb.i_start = 1'($urandom_range(0, 3) == 0);
            ifb.i_bin   = 8'($urandom);
            rst         = ($urandom_range(0, 79) == 0);
        end
        @(negedge clk);
        ifa.i_start = 1'b0; ifb.i_start = 1'b0; rst = 1'b0;
        repeat (25) @(posedge clk);
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
